// File: rtl/wb_target_slice.sv
// Registered single-outstanding Wishbone classic stage between one interconnect
// target port and its target, with a watchdog that errors out hung cycles.
module wb_target_slice #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WB_ADDR_WIDTH-1:0]   adr,
  input  logic [WB_DATA_WIDTH-1:0]   dat_w,
  input  logic [WB_DATA_WIDTH/8-1:0] sel,
  input  logic                       cyc,
  input  logic                       stb,
  input  logic                       we,
  output logic [WB_DATA_WIDTH-1:0]   dat_r,
  output logic                       ack,
  output logic                       err,
  output logic [WB_ADDR_WIDTH-1:0]   tadr,
  output logic [WB_DATA_WIDTH-1:0]   tdat_w,
  output logic [WB_DATA_WIDTH/8-1:0] tsel,
  output logic                       tcyc,
  output logic                       tstb,
  output logic                       twe,
  input  logic [WB_DATA_WIDTH-1:0]   tdat_r,
  input  logic                       tack,
  input  logic                       terr,
  output logic [15:0]                timeout_cnt
);

  localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;
  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t                     state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0]   tadr_q, tadr_d;
  logic [WB_DATA_WIDTH-1:0]   tdat_w_q, tdat_w_d;
  logic [SEL_W-1:0]           tsel_q, tsel_d;
  logic                       twe_q, twe_d;
  logic                       tcyc_q, tcyc_d;
  logic                       tstb_q, tstb_d;
  logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [15:0]                tocnt_q, tocnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tadr_q   <= '0;
      tdat_w_q <= '0;
      tsel_q   <= '0;
      twe_q    <= 1'b0;
      tcyc_q   <= 1'b0;
      tstb_q   <= 1'b0;
      dat_r_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      tocnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      tadr_q   <= tadr_d;
      tdat_w_q <= tdat_w_d;
      tsel_q   <= tsel_d;
      twe_q    <= twe_d;
      tcyc_q   <= tcyc_d;
      tstb_q   <= tstb_d;
      dat_r_q  <= dat_r_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      tocnt_q  <= tocnt_d;
    end
  end

  // Next-state: abort beats any response, err beats ack, response beats watchdog.
  always_comb begin
    state_d  = state_q;
    tadr_d   = tadr_q;
    tdat_w_d = tdat_w_q;
    tsel_d   = tsel_q;
    twe_d    = twe_q;
    tcyc_d   = tcyc_q;
    tstb_d   = tstb_q;
    dat_r_d  = dat_r_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    tocnt_d  = tocnt_q;
    unique case (state_q)
      IDLE: begin
        if (cyc && stb) begin
          tadr_d   = adr;
          tdat_w_d = dat_w;
          tsel_d   = sel;
          twe_d    = we;
          tcyc_d   = 1'b1;
          tstb_d   = 1'b1;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (!cyc) begin
          tcyc_d  = 1'b0;
          tstb_d  = 1'b0;
          state_d = IDLE;
        end else if (terr) begin
          err_d   = 1'b1;
          dat_r_d = '0;
          tcyc_d  = 1'b0;
          tstb_d  = 1'b0;
          state_d = RSP;
        end else if (tack) begin
          ack_d   = 1'b1;
          dat_r_d = tdat_r;
          tcyc_d  = 1'b0;
          tstb_d  = 1'b0;
          state_d = RSP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          dat_r_d = '0;
          tcyc_d  = 1'b0;
          tstb_d  = 1'b0;
          if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
          state_d = RSP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign tadr        = tadr_q;
  assign tdat_w      = tdat_w_q;
  assign tsel        = tsel_q;
  assign twe         = twe_q;
  assign tcyc        = tcyc_q;
  assign tstb        = tstb_q;
  assign dat_r       = dat_r_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_wb_target_slice.sv
// Scoreboard bench for wb_target_slice: directed scenarios plus random
// transactions, upstream responses checked by an independent monitor.
module tb_wb_target_slice;

  localparam int TO       = 8;
  localparam int BOUND    = 40;
  localparam int M_ACK    = 0;
  localparam int M_ERR    = 1;
  localparam int M_BOTH   = 2;
  localparam int M_HANG   = 3;
  localparam int M_ABORT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w, dat_r, tadr, tdat_w, tdat_r;
  logic [3:0]  sel, tsel;
  logic        cyc, stb, we, ack, err, tcyc, tstb, twe, tack, terr;
  logic [15:0] timeout_cnt;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [15:0] to;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] to_model = '0;

  always #5 clk = ~clk;

  wb_target_slice #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .adr(adr), .dat_w(dat_w), .sel(sel), .cyc(cyc), .stb(stb), .we(we),
    .dat_r(dat_r), .ack(ack), .err(err),
    .tadr(tadr), .tdat_w(tdat_w), .tsel(tsel), .tcyc(tcyc), .tstb(tstb), .twe(twe),
    .tdat_r(tdat_r), .tack(tack), .terr(terr),
    .timeout_cnt(timeout_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every upstream response must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got ack=%b err=%b expected none", ack, err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp", 128'({ack, err, dat_r, timeout_cnt}), 128'({e.ack, e.err, e.dat, e.to}));
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] rd, input int dly, input int mode);
    exp_t e;
    int   k;
    int   want_k;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    e.ack = (mode == M_ACK);
    e.err = (mode == M_ERR) || (mode == M_BOTH) || (mode == M_HANG);
    e.dat = (mode == M_ACK) ? rd : 32'd0;
    if (mode == M_HANG && to_model != 16'hFFFF) to_model = to_model + 16'd1;
    e.to = to_model;
    if (mode != M_ABORT) exp_q.push_back(e);
    for (k = 0; k < BOUND; k++) begin
      @(posedge clk); #1;
      tack = 1'b0; terr = 1'b0;
      if (tstb !== 1'b1) break;
      chk("treq_stable", 128'({tcyc, twe, tadr, tdat_w, tsel}), 128'({1'b1, w, a, d, s}));
      if (mode != M_HANG && k == dly) begin
        tdat_r = rd;
        case (mode)
          M_ACK:   tack = 1'b1;
          M_ERR:   terr = 1'b1;
          M_BOTH:  begin tack = 1'b1; terr = 1'b1; end
          default: begin tack = 1'b1; cyc = 1'b0; stb = 1'b0; end
        endcase
      end
    end
    want_k = (mode == M_HANG) ? TO : dly + 1;
    chk("tstb_cycles", 128'(k), 128'(want_k));
    if (mode == M_ABORT) begin
      chk("abort_idle", 128'({tcyc, tstb, ack, err}), 128'(0));
    end else begin
      chk("rsp_latency", 128'({ack, err, tcyc}), 128'({e.ack, e.err, 1'b0}));
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      chk("rsp_single_pulse", 128'({ack, err}), 128'(0));
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic reset_mid_req();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0040; sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_req", 128'({tcyc, tstb}), 128'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 128'({tcyc, tstb, ack, err, timeout_cnt}), 128'(0));
    cyc = 1'b0; stb = 1'b0;
    to_model = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = '0; tdat_r = '0; tack = 1'b0; terr = 1'b0;
    #3;
    chk("reset_state", 128'({tcyc, tstb, twe, ack, err, tadr, tdat_w, tsel, timeout_cnt}), 128'(0));
    chk("reset_dat_r", 128'(dat_r), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, M_ACK);
    txn(1'b1, 32'h0000_2004, 32'h1234_5678, 4'b0101, 32'h0, 5, M_ACK);
    txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'h5555_AAAA, 0, M_HANG);
    txn(1'b0, 32'h0000_3004, 32'h0, 4'hF, 32'h5555_AAAA, 0, M_HANG);
    chk("timeout_cnt_two", 128'(timeout_cnt), 128'(16'd2));
    txn(1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'hCAFE_F00D, 1, M_BOTH);
    txn(1'b0, 32'h0000_5000, 32'h0, 4'hF, 32'h1111_2222, 2, M_ABORT);
    txn(1'b0, 32'h0000_5004, 32'h0, 4'hF, 32'h3333_4444, 7, M_ACK);
    txn(1'b1, 32'h0000_5008, 32'hA5A5_5A5A, 4'h3, 32'h0, 3, M_ERR);

    reset_mid_req();
    txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 32'h0BAD_F00D, 1, M_ACK);

    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    chk("final_timeout_cnt", 128'(timeout_cnt), 128'(to_model));
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
